// File: rtl/config_pkg.sv
// Shared configuration for the boot-time instruction memory loader.
package config_pkg;

    // Word-address width of instruction memory (depth = 2**IMemAddrWidth words).
    localparam int unsigned IMemAddrWidth = 10;

    // Frame-start marker.
    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write/status bundle of the loader.
// The master modport is the loader side; the slave modport is its environment.
interface imem_loader_if #(
    parameter int unsigned AddrWidth = 10
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 imem_we;
    logic [AddrWidth-1:0] imem_addr;
    logic [31:0]          imem_wdata;
    logic                 core_reset;
    logic                 done;
    logic                 error;

    modport master (
        input  rx_data, rx_valid,
        output imem_we, imem_addr, imem_wdata, core_reset, done, error
    );

    modport slave (
        output rx_data, rx_valid,
        input  imem_we, imem_addr, imem_wdata, core_reset, done, error
    );

endinterface

// File: rtl/byte_to_word.sv
// Little-endian 4-byte assembler. The first three bytes are buffered; the
// fourth arrives live, so the full word and its ready strobe are valid in the
// same cycle as the fourth byte.
module byte_to_word (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  idx_q;
    logic [23:0] buf_q;

    // Byte counter and lower-byte buffer; clear restarts word alignment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= 2'd0;
            buf_q <= 24'd0;
        end else if (clear) begin
            idx_q <= 2'd0;
            buf_q <= 24'd0;
        end else if (byte_valid) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    buf_q[7:0]   <= byte_data;
                2'd1:    buf_q[15:8]  <= byte_data;
                2'd2:    buf_q[23:16] <= byte_data;
                default: ;
            endcase
        end
    end

    // Fourth byte completes the word combinationally.
    always_comb begin
        word       = {byte_data, buf_q};
        word_ready = byte_valid && (idx_q == 2'd3);
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses SyncByte/LEN/payload/CSUM frames from the UART byte
// stream, writes assembled words into imem and releases the core only once a
// checksum-verified image is in place.
module imem_loader #(
    parameter int unsigned IMemAddrWidth = config_pkg::IMemAddrWidth,
    parameter logic [7:0]  SyncByte      = config_pkg::SyncByte
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus
);

    import config_pkg::*;

    // One extra bit so an image of exactly 'depth' words does not wrap.
    localparam int unsigned IdxWidth = IMemAddrWidth + 1;
    localparam logic [16:0] Depth    = 17'(2 ** IMemAddrWidth);

    loader_state_t            state_q, state_d;
    logic [15:0]              len_q, len_d;
    logic [IdxWidth-1:0]      idx_q, idx_d;
    logic [7:0]               csum_q, csum_d;
    logic                     we_q, we_d;
    logic [IMemAddrWidth-1:0] addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic                     done_q, error_q, core_reset_q;

    logic        b2w_clear;
    logic        b2w_valid;
    logic [31:0] word;
    logic        word_ready;
    logic [16:0] n_ext;
    logic [16:0] next_idx_ext;
    logic        is_sync;

    byte_to_word u_byte_to_word (
        .clk        (clk),
        .reset      (reset),
        .clear      (b2w_clear),
        .byte_valid (b2w_valid),
        .byte_data  (bus.rx_data),
        .word       (word),
        .word_ready (word_ready)
    );

    // Frame parser: next state, counters, checksum and write-port values.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        b2w_clear = 1'b0;
        b2w_valid = 1'b0;

        is_sync      = bus.rx_valid && (bus.rx_data == SyncByte);
        n_ext        = {1'b0, bus.rx_data, len_q[7:0]};
        next_idx_ext = 17'(idx_q) + 17'd1;

        unique case (state_q)
            IDLE: begin
                if (is_sync) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (bus.rx_valid) begin
                    len_d[7:0] = bus.rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                // Realign the assembler before any payload byte can arrive.
                b2w_clear = 1'b1;
                if (bus.rx_valid) begin
                    len_d[15:8] = bus.rx_data;
                    idx_d       = '0;
                    csum_d      = 8'd0;
                    if (n_ext > Depth) begin
                        state_d = ERROR;
                    end else if (n_ext == 17'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                b2w_valid = bus.rx_valid;
                if (bus.rx_valid) begin
                    csum_d = csum_q ^ bus.rx_data;
                end
                if (word_ready) begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[IMemAddrWidth-1:0];
                    wdata_d = word;
                    idx_d   = idx_q + 1'b1;
                    if (next_idx_ext == {1'b0, len_q}) state_d = CSUM;
                end
            end
            CSUM: begin
                if (bus.rx_valid) begin
                    state_d = (bus.rx_data == csum_q) ? DONE : ERROR;
                end
            end
            DONE, ERROR: begin
                if (is_sync) state_d = LEN_LO;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; status follows the next state so
    // it changes on the same edge that accepts the deciding byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= 16'd0;
            idx_q        <= '0;
            csum_q       <= 8'd0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            csum_q       <= csum_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            done_q       <= (state_d == DONE);
            error_q      <= (state_d == ERROR);
            core_reset_q <= (state_d != DONE);
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.core_reset = core_reset_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance (a) and a 16-word
// instance (b) for the length-overflow boundary.
module tb_imem_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_a, reset_b;

    imem_loader_if #(.AddrWidth(10)) ifa ();
    imem_loader_if #(.AddrWidth(4))  ifb ();

    imem_loader #(.IMemAddrWidth(10), .SyncByte(8'hA5)) dut_a (
        .clk   (clk),
        .reset (reset_a),
        .bus   (ifa)
    );

    imem_loader #(.IMemAddrWidth(4), .SyncByte(8'hA5)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .bus   (ifb)
    );

    int tests = 0;
    int fails = 0;

    // Instruction memory models fed by the write ports.
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:15];
    int          wcnt_a = 0;
    int          wcnt_b = 0;
    int          last_b = -1;

    always @(posedge clk) begin
        if (ifa.imem_we) begin
            mem_a[ifa.imem_addr] <= ifa.imem_wdata;
            wcnt_a <= wcnt_a + 1;
        end
        if (ifb.imem_we) begin
            mem_b[ifb.imem_addr] <= ifb.imem_wdata;
            wcnt_b <= wcnt_b + 1;
            last_b <= int'(ifb.imem_addr);
        end
    end

    logic [31:0] prog [0:5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One byte for one cycle; consecutive calls give back-to-back rx_valid.
    task automatic send(input bit sel, input logic [7:0] b);
        if (sel) begin
            ifb.rx_data = b;
            ifb.rx_valid = 1'b1;
        end else begin
            ifa.rx_data = b;
            ifa.rx_valid = 1'b1;
        end
        @(negedge clk);
        ifa.rx_valid = 1'b0;
        ifb.rx_valid = 1'b0;
    endtask

    // Sends a word LSB first; the write must appear exactly one cycle after
    // the fourth byte and not earlier.
    task automatic send_word(input bit sel, input logic [31:0] w, input int addr);
        logic [31:0] we, ad, wd;
        for (int k = 0; k < 4; k++) begin
            send(sel, w[8*k +: 8]);
            we = sel ? 32'(ifb.imem_we)    : 32'(ifa.imem_we);
            ad = sel ? 32'(ifb.imem_addr)  : 32'(ifa.imem_addr);
            wd = sel ? ifb.imem_wdata      : ifa.imem_wdata;
            if (k < 3) begin
                check("we_idle", we, 32'd0);
            end else begin
                check("we_pulse", we, 32'd1);
                check("we_addr", ad, 32'(addr));
                check("we_wdata", wd, w);
            end
        end
    endtask

    task automatic check_reset_a();
        check("rst_we",         32'(ifa.imem_we),    32'd0);
        check("rst_addr",       32'(ifa.imem_addr),  32'd0);
        check("rst_wdata",      ifa.imem_wdata,      32'd0);
        check("rst_core_reset", 32'(ifa.core_reset), 32'd1);
        check("rst_done",       32'(ifa.done),       32'd0);
        check("rst_error",      32'(ifa.error),      32'd0);
    endtask

    task automatic send_nominal_a(input logic [7:0] csum, input int gap);
        send(0, 8'hA5);
        send(0, 8'h06);
        send(0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            send_word(0, prog[i], i);
            repeat (gap) @(negedge clk);
        end
        check("pre_csum_done", 32'(ifa.done), 32'd0);
        send(0, csum);
    endtask

    int          base;
    logic [31:0] w;
    logic [7:0]  cs;

    initial begin
        prog[0] = 32'h5000_0117;
        prog[1] = 32'h5001_0113;
        prog[2] = 32'h0020_0313;
        prog[3] = 32'hfff3_0313;
        prog[4] = 32'hfe03_1ee3;
        prog[5] = 32'h0000_006f;
        ifa.rx_data = 8'd0;
        ifa.rx_valid = 1'b0;
        ifb.rx_data = 8'd0;
        ifb.rx_valid = 1'b0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_a();
        check("rst_b_core_reset", 32'(ifb.core_reset), 32'd1);
        reset_a = 1'b0;
        reset_b = 1'b0;
        @(negedge clk);

        // Nominal image, XOR of all payload bytes = 0x46.
        base = wcnt_a;
        send_nominal_a(8'h46, 0);
        check("nom_done",       32'(ifa.done),       32'd1);
        check("nom_core_reset", 32'(ifa.core_reset), 32'd0);
        check("nom_error",      32'(ifa.error),      32'd0);
        check("nom_we_after",   32'(ifa.imem_we),    32'd0);
        check("nom_writes",     32'(wcnt_a - base),  32'd6);
        for (int i = 0; i < 6; i++) check("nom_mem", mem_a[i], prog[i]);

        // Bad checksum with idle gaps between words.
        base = wcnt_a;
        send(0, 8'hA5);
        check("resync_done",       32'(ifa.done),       32'd0);
        check("resync_core_reset", 32'(ifa.core_reset), 32'd1);
        send(0, 8'h06);
        send(0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            send_word(0, prog[i], i);
            @(negedge clk);
        end
        send(0, 8'hB9);
        check("bad_error",      32'(ifa.error),      32'd1);
        check("bad_core_reset", 32'(ifa.core_reset), 32'd1);
        check("bad_done",       32'(ifa.done),       32'd0);
        check("bad_writes",     32'(wcnt_a - base),  32'd6);
        send(0, 8'h00);
        check("err_ignores",    32'(ifa.error),      32'd1);

        // Recovery with a good frame.
        send_nominal_a(8'h46, 0);
        check("rec_error", 32'(ifa.error), 32'd0);
        check("rec_done",  32'(ifa.done),  32'd1);

        // Empty image.
        base = wcnt_a;
        send(0, 8'hA5);
        send(0, 8'h00);
        send(0, 8'h00);
        send(0, 8'h00);
        check("empty_done",       32'(ifa.done),       32'd1);
        check("empty_core_reset", 32'(ifa.core_reset), 32'd0);
        check("empty_writes",     32'(wcnt_a - base),  32'd0);

        // Noise then a frame whose payload contains the sync byte twice.
        send(0, 8'h3C);
        send(0, 8'hFF);
        check("noise_done", 32'(ifa.done), 32'd1);
        base = wcnt_a;
        send(0, 8'hA5);
        send(0, 8'h01);
        send(0, 8'h00);
        send_word(0, 32'h12A5_C3A5, 0);
        send(0, 8'hD1);
        check("emb_done",   32'(ifa.done),      32'd1);
        check("emb_writes", 32'(wcnt_a - base), 32'd1);
        check("emb_mem",    mem_a[0],           32'h12A5_C3A5);

        // Asynchronous reset after two payload bytes.
        base = wcnt_a;
        send(0, 8'hA5);
        send(0, 8'h06);
        send(0, 8'h00);
        send(0, 8'h17);
        send(0, 8'h01);
        #2 reset_a = 1'b1;
        #1 check_reset_a();
        @(negedge clk);
        reset_a = 1'b0;
        @(negedge clk);
        check("abort_writes", 32'(wcnt_a - base), 32'd0);
        send_nominal_a(8'h46, 0);
        check("reload_done",   32'(ifa.done),      32'd1);
        check("reload_writes", 32'(wcnt_a - base), 32'd6);
        for (int i = 0; i < 6; i++) check("reload_mem", mem_a[i], prog[i]);

        // Depth-16 instance: 17 words overflows, 16 words fits exactly.
        send(1, 8'hA5);
        send(1, 8'h11);
        send(1, 8'h00);
        check("ovf_error",      32'(ifb.error),      32'd1);
        check("ovf_core_reset", 32'(ifb.core_reset), 32'd1);
        check("ovf_writes",     32'(wcnt_b),         32'd0);
        send(1, 8'hA5);
        send(1, 8'h10);
        send(1, 8'h00);
        check("full_error_clr", 32'(ifb.error), 32'd0);
        cs = 8'h00;
        for (int i = 0; i < 16; i++) begin
            w = 32'hC0DE_0000 | (32'(i) * 32'h0101_0011);
            cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            send_word(1, w, i);
        end
        send(1, cs);
        check("full_done",   32'(ifb.done),  32'd1);
        check("full_writes", 32'(wcnt_b),    32'd16);
        check("full_last",   32'(last_b),    32'd15);
        check("full_mem15",  mem_b[15],      32'hC0DE_0000 | (32'd15 * 32'h0101_0011));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
